pll_lock_monitor: RTL
=====================

Name: pll_lock_monitor

Overview:
Synthesizable, parametrised PLL lock supervisor for NUM_CH independent pll_lock inputs, all sampled in the clk_tb domain. Per channel it tracks lock acquisition after an arm (start) pulse and flags three faults: acquisition timeout, loss of lock, and excess relock. It keeps per-channel lock counters, sticky error codes and a global saturating error counter. It replaces ad-hoc lock-pulse checking in PLL IP benches and is reused on-chip as a clock-health monitor.

Parameters:
NUM_CH, 2, number of monitored PLL lock inputs (>=1)
SYNC_STAGES, 2, synchroniser flops per pll_lock input (>=2)
TIMEOUT_CYC, 1024, clk_tb cycles allowed in WAIT before timeout fault (>=2)
MAX_LOCKS, 1, lock acquisitions allowed per arm; one more is an excess fault (>=1)
CNT_W, 2, per-channel lock counter width; must hold MAX_LOCKS
ERR_CNT_W, 3, global error counter width

Ports:
clk_tb  in  1  clock; all logic on its rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle arm pulse, applies to all channels
clr_err  in  1  clears err_flag, err_code and err_cnt
pll_lock  in  NUM_CH  raw lock inputs, asynchronous to clk_tb
locked  out  NUM_CH  channel in LOCKED state
fault  out  NUM_CH  channel in FAULT state
err_flag  out  NUM_CH  sticky: any error since last clear or arm
err_code  out  2*NUM_CH  sticky first error per channel: 0 none, 1 timeout, 2 loss, 3 excess
err_pulse  out  NUM_CH  one-cycle strobe on each error event
lock_cnt  out  CNT_W*NUM_CH  LOCKED entries since arm, saturating
err_cnt  out  ERR_CNT_W  cycles containing >=1 error event, saturating at all-ones
all_locked  out  1  AND of locked

Behaviour:
- Reset: every output 0, all channels IDLE, synchronisers and timers 0.
- Sync: ls[ch] is the output of a SYNC_STAGES-flop chain. FSM decisions use only ls. Latency from a pll_lock edge to the locked change is SYNC_STAGES+1 cycles.
- IDLE: wait for start, then go to WAIT.
- WAIT: timer increments every cycle.
  - ls=1 and lock_cnt<MAX_LOCKS: go to LOCKED, lock_cnt+1, timer cleared.
  - ls=1 and lock_cnt==MAX_LOCKS: go to FAULT with code 3 (excess).
  - ls=0 and timer==TIMEOUT_CYC-1: go to FAULT with code 1 (timeout). The fault is therefore registered TIMEOUT_CYC cycles after entering WAIT.
- LOCKED: ls=0 raises a loss error (code 2), then go to WAIT with the timer cleared.
- FAULT: hold. Exit only on start.
- start in any state: go to WAIT with timer=0, lock_cnt=0, err_flag=0 and err_code=0 for every channel; err_cnt is not touched. start takes priority over all same-cycle transitions and errors on that edge. If ls is already 1 at arm, the channel enters LOCKED on the next edge.
- Error event: err_pulse is high in the cycle after the transition edge, i.e. registered alongside the new state. err_flag is set. err_code is written only if it is currently 0, so the first error is kept.
- err_cnt increments by exactly 1 per cycle in which any err_pulse is set, regardless of how many channels fire; it saturates and never wraps.
- clr_err: clears err_flag, err_code and err_cnt. FSM state and lock_cnt are unchanged.
- clr_err coincident with a new error: the new error wins (flag set, code written, err_cnt becomes 1).
- Timer width is $clog2(TIMEOUT_CYC). The timer never wraps because the timeout fires first.
- Outputs locked and fault are decoded directly from the state register (no extra latency).

Decomposition:
- pll_mon_pkg holds:
  - the state enum {IDLE, WAIT, LOCKED, FAULT};
  - the error code constants ERR_NONE/TIMEOUT/LOSS/EXCESS (2-bit);
  - a helper function for saturating increment.
- Sub-module pll_lock_chan contains the synchroniser, FSM, timer, lock_cnt, err_flag, err_code and err_pulse for one channel. The top instantiates it NUM_CH times via generate.
- The top adds the err_cnt OR-reduction/saturation logic and all_locked.

Test Plan:
- Defaults. rst_n low at t=0, high at 20 ns. start, then pll_lock[0]=1 after 50 cycles -> locked[0]=1 at exactly cycle 53 after WAIT entry, lock_cnt[0]=1, err_flag=0.
- pll_lock[1] held 0 after start -> fault[1]=1, err_code[1]=1, one err_pulse 1024 cycles after start, err_cnt=1.
- Ch0 locked, then pll_lock[0] drops -> locked[0]=0 3 cycles later, err_code[0]=2. Relock -> FAULT, err_code stays 2, err_cnt=2.
- Both channels raise errors in the same cycle (forced timeout, TIMEOUT_CYC=16) -> err_cnt increments by 1 only. Nine error cycles with ERR_CNT_W=3 -> err_cnt saturates at 7.
- clr_err asserted in the same cycle as a timeout error -> err_flag=1, err_code=1, err_cnt=1. clr_err alone afterwards -> all three are 0 and fault stays 1. Next start -> WAIT.
- Async rst_n asserted mid-WAIT (timer=500) -> all outputs 0 immediately, with no clock edge required. After release, no activity until start.

Source files
------------

// File: rtl/pll_mon_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        LOCKED,
        FAULT
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_LOSS    = 2'd2;
    localparam logic [1:0] ERR_EXCESS  = 2'd3;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/pll_lock_chan.sv
// One supervised PLL lock input: synchroniser, lock FSM, timeout timer and sticky error state.
module pll_lock_chan
    import pll_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned MAX_LOCKS   = 1,
    parameter int unsigned CNT_W       = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             clr_err_i,
    input  logic             pll_lock_i,
    output logic             locked_o,
    output logic             fault_o,
    output logic             err_flag_o,
    output logic [1:0]       err_code_o,
    output logic             err_pulse_o,
    output logic             err_ev_o,
    output logic [CNT_W-1:0] lock_cnt_o
);

    localparam int unsigned      TW         = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    state_e                 state_q;
    logic [TW-1:0]          timer_q;
    logic [CNT_W-1:0]       lock_cnt_q;
    logic                   err_flag_q;
    logic [1:0]             err_code_q;
    logic                   err_pulse_q;

    logic       ls;
    logic       below_max;
    logic       err_ev;
    logic [1:0] err_new;
    logic [1:0] code_base;

    assign ls        = sync_q[SYNC_STAGES-1];
    assign below_max = 32'(lock_cnt_q) < MAX_LOCKS;
    assign code_base = clr_err_i ? ERR_NONE : err_code_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_i};
        end
    end

    always_comb begin
        err_ev  = 1'b0;
        err_new = ERR_NONE;
        unique case (state_q)
            WAIT: begin
                if (ls) begin
                    if (!below_max) begin
                        err_ev  = 1'b1;
                        err_new = ERR_EXCESS;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    err_ev  = 1'b1;
                    err_new = ERR_TIMEOUT;
                end
            end
            LOCKED: begin
                if (!ls) begin
                    err_ev  = 1'b1;
                    err_new = ERR_LOSS;
                end
            end
            default: ;
        endcase
    end

    // start overrides everything on its edge, so the event never leaves the channel then
    assign err_ev_o = err_ev & ~start_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            lock_cnt_q  <= '0;
            err_flag_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_pulse_q <= 1'b0;
        end else if (start_i) begin
            state_q     <= WAIT;
            timer_q     <= '0;
            lock_cnt_q  <= '0;
            err_flag_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= err_ev;
            err_flag_q  <= err_ev | (err_flag_q & ~clr_err_i);
            err_code_q  <= (err_ev && code_base == ERR_NONE) ? err_new : code_base;
            unique case (state_q)
                IDLE: ;
                WAIT: begin
                    if (ls) begin
                        if (below_max) begin
                            state_q    <= LOCKED;
                            lock_cnt_q <= CNT_W'(sat_inc(32'(lock_cnt_q), 32'(CNT_SAT)));
                            timer_q    <= '0;
                        end else begin
                            state_q <= FAULT;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        state_q <= FAULT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!ls) begin
                        state_q <= WAIT;
                        timer_q <= '0;
                    end
                end
                FAULT: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign locked_o    = (state_q == LOCKED);
    assign fault_o     = (state_q == FAULT);
    assign err_flag_o  = err_flag_q;
    assign err_code_o  = err_code_q;
    assign err_pulse_o = err_pulse_q;
    assign lock_cnt_o  = lock_cnt_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// Multi-channel PLL lock supervisor: per-channel monitors plus a global saturating error-cycle counter.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned MAX_LOCKS   = 1,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned ERR_CNT_W   = 3
) (
    input  logic                    clk_tb,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    clr_err,
    input  logic [NUM_CH-1:0]       pll_lock,
    output logic [NUM_CH-1:0]       locked,
    output logic [NUM_CH-1:0]       fault,
    output logic [NUM_CH-1:0]       err_flag,
    output logic [2*NUM_CH-1:0]     err_code,
    output logic [NUM_CH-1:0]       err_pulse,
    output logic [CNT_W*NUM_CH-1:0] lock_cnt,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    output logic                    all_locked
);

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    logic [NUM_CH-1:0]    err_ev;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        pll_lock_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .MAX_LOCKS   (MAX_LOCKS),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk_i       (clk_tb),
            .rst_n_i     (rst_n),
            .start_i     (start),
            .clr_err_i   (clr_err),
            .pll_lock_i  (pll_lock[ch]),
            .locked_o    (locked[ch]),
            .fault_o     (fault[ch]),
            .err_flag_o  (err_flag[ch]),
            .err_code_o  (err_code[2*ch +: 2]),
            .err_pulse_o (err_pulse[ch]),
            .err_ev_o    (err_ev[ch]),
            .lock_cnt_o  (lock_cnt[CNT_W*ch +: CNT_W])
        );
    end

    // Clear first, then count, so an error coincident with clr_err leaves the count at 1
    always_comb begin
        err_cnt_d = clr_err ? '0 : err_cnt_q;
        if (|err_ev) begin
            err_cnt_d = ERR_CNT_W'(sat_inc(32'(err_cnt_d), 32'(ERR_CNT_MAX)));
        end
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt    = err_cnt_q;
    assign all_locked = &locked;

endmodule
